adex_neuron_array: RTL and testbench
====================================

ADEX_NEURON_ARRAY -- requirements
Module: adex_neuron_array

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of time-multiplexed neuron channels (2..64).
REQ-002 SHALL have parameter DW, default 16, signed width of vmem, w and input current.
REQ-003 SHALL have parameter LUT_DEPTH, default 16, exp() lookup entries (power of 2).
REQ-004 SHALL have parameter REFRAC, default 2, refractory length in channel updates (0 disables).
REQ-005 clk  input  1  single clock, all logic on rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 in_valid  input  1  update request valid.
REQ-008 in_ready  output  1  block can accept a request.
REQ-009 in_ch  input  CW=$clog2(NUM_CH)  target channel.
REQ-010 in_cur  input  DW  signed input current.
REQ-011 spike_valid  output  1  one-cycle spike pulse.
REQ-012 spike_ch  output  CW  channel that spiked.
REQ-013 out_vmem  output  DW  vmem of last updated channel, written value.
REQ-014 out_w  output  DW  w of last updated channel, written value.

Function
REQ-015 SHALL store vmem[NUM_CH], w[NUM_CH], refr[NUM_CH] in internal register arrays.
REQ-016 SHALL run FSM IDLE->LOAD->EXP->UPDATE->WRITE->IDLE, one cycle per state.
REQ-017 in_ready SHALL be 1 only in IDLE; transfer occurs when in_valid&&in_ready.
REQ-018 spike_valid/out_vmem/out_w SHALL update in WRITE, 4 cycles after transfer; next transfer earliest 5 cycles after previous.
REQ-019 in_ch >= NUM_CH SHALL be accepted and discarded (no state change, no spike, outputs hold).
REQ-020 UPDATE: v' = v + ((V_REST - v) >>> TAU_SHIFT) + exp_q(v) + in_cur - w, computed at DW+3 bits, saturated to DW signed.
REQ-021 exp_q(v) SHALL be 0 for v < V_EXP_MIN, else LUT[min((v - V_EXP_MIN) >>> IDX_SHIFT, LUT_DEPTH-1)].
REQ-022 w' = w - (w >>> TAUW_SHIFT), saturated to DW.
REQ-023 If v' >= V_PEAK: vmem <= V_RESET, w <= sat(w' + B), refr <= REFRAC, spike_valid=1, spike_ch=channel.
REQ-024 If refr != 0 at LOAD: vmem <= V_RESET, in_cur ignored, w decays per REQ-022, refr decrements, no spike.
REQ-025 spike_valid SHALL be 0 in every cycle except a spiking WRITE.
REQ-026 Updates to one channel SHALL never alter another channel's state.

Reset
REQ-027 rst SHALL set all vmem to V_RESET, all w and refr to 0, FSM to IDLE.
REQ-028 During rst: in_ready=0, spike_valid=0, spike_ch=0, out_vmem=V_RESET, out_w=0.
REQ-029 rst mid-update SHALL abort it; no spike or write for that request.

Configuration
REQ-030 Macro ADEX_ADAPT_EN defined: adaptation per REQ-022/REQ-023 active.
REQ-031 ADEX_ADAPT_EN undefined: w storage removed, w treated as 0, out_w tied 0, B ignored.

Structure
REQ-032 Package adex_pkg SHALL hold V_REST=0, V_RESET=0, V_PEAK=1000, V_EXP_MIN=512, IDX_SHIFT=6, TAU_SHIFT=3, TAUW_SHIFT=4, B=64, exp LUT table, FSM state enum.
REQ-033 Sub-module adex_exp_lut SHALL implement REQ-021 combinationally, registered in EXP state.

Verification
REQ-034 rst, then ch1 cur=400 -> out_vmem=400, no spike; then ch1 cur=0 -> out_vmem=350.
REQ-035 ch2 cur=1200 -> spike_valid=1 4 cycles after transfer, spike_ch=2, out_vmem=0, out_w=64 (0 without ADEX_ADAPT_EN).
REQ-036 After REQ-035, two ch2 cur=1200 updates -> no spike, out_vmem=0; third -> spike again.
REQ-037 ch0 cur=-32768 twice -> out_vmem=-32768 both times (saturation), ch1..3 unchanged.
REQ-038 in_valid held high continuously -> in_ready pulses every 5 cycles; in_ch=5 (NUM_CH=4) -> no state change.
REQ-039 rst asserted in UPDATE of spiking request -> no spike_valid, all state at reset values.

Source files
------------

// File: rtl/adex_pkg.sv
// adex_pkg: shared constants, exp() table and FSM encoding for the
// AdEx neuron array. Adaptation is enabled by defining ADEX_ADAPT_EN.
package adex_pkg;

  localparam int V_REST     = 0;
  localparam int V_RESET    = 0;
  localparam int V_PEAK     = 1000;
  localparam int V_EXP_MIN  = 512;
  localparam int IDX_SHIFT  = 6;
  localparam int TAU_SHIFT  = 3;
  localparam int TAUW_SHIFT = 4;
  localparam int B          = 64;

  // Quantised exp() kick, one entry per 64 mV-units above V_EXP_MIN.
  localparam int EXP_LUT_N = 16;
  localparam int EXP_LUT [EXP_LUT_N] = '{
    4,   6,   9,   13,  19,  28,  41,  60,
    88,  128, 188, 275, 402, 589, 862, 1263
  };

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_EXP,
    S_UPDATE,
    S_WRITE
  } adex_state_e;

  // Deeper LUT configurations reuse the last table entry.
  function automatic int exp_lut_val(input int idx);
    if (idx < 0) return 0;
    if (idx >= EXP_LUT_N) return EXP_LUT[EXP_LUT_N-1];
    return EXP_LUT[idx[3:0]];
  endfunction

endpackage

// File: rtl/adex_exp_lut.sv
// adex_exp_lut: combinational exp() term for one membrane value.
// Ports: v_i (signed vmem), exp_o (signed exp kick, 0 below V_EXP_MIN).
module adex_exp_lut
  import adex_pkg::*;
#(
  parameter int DW        = 16,
  parameter int LUT_DEPTH = 16
) (
  input  logic signed [DW-1:0] v_i,
  output logic signed [DW-1:0] exp_o
);

  localparam int XW = DW + 1;

  logic signed [XW-1:0] off;
  logic        [XW-1:0] idx;

  always_comb begin
    off   = XW'(v_i) - XW'(V_EXP_MIN);
    idx   = off >>> IDX_SHIFT;
    exp_o = '0;
    if (!off[XW-1]) begin
      if (idx > XW'(LUT_DEPTH - 1)) begin
        exp_o = DW'(exp_lut_val(LUT_DEPTH - 1));
      end else begin
        exp_o = DW'(exp_lut_val(int'(idx)));
      end
    end
  end

endmodule

// File: rtl/adex_neuron_array.sv
// adex_neuron_array: NUM_CH time-multiplexed AdEx neurons, one update per
// 5-cycle IDLE/LOAD/EXP/UPDATE/WRITE pass. Define ADEX_ADAPT_EN to enable
// the adaptation current w.
// Ports: clk, rst (sync, active-high); in_valid/in_ready/in_ch/in_cur
// request; spike_valid/spike_ch pulse; out_vmem/out_w last written state.
module adex_neuron_array
  import adex_pkg::*;
#(
  parameter int NUM_CH    = 4,
  parameter int DW        = 16,
  parameter int LUT_DEPTH = 16,
  parameter int REFRAC    = 2,
  localparam int CW       = $clog2(NUM_CH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [CW-1:0]        in_ch,
  input  logic signed [DW-1:0] in_cur,
  output logic                 spike_valid,
  output logic [CW-1:0]        spike_ch,
  output logic signed [DW-1:0] out_vmem,
  output logic signed [DW-1:0] out_w
);

  localparam int XW = DW + 3;
  localparam int RW = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;

  localparam logic signed [XW-1:0] SMAX =
    {4'b0000, {(DW-1){1'b1}}};
  localparam logic signed [XW-1:0] SMIN =
    {4'b1111, {(DW-1){1'b0}}};

  function automatic logic signed [DW-1:0] sat(
    input logic signed [XW-1:0] x
  );
    if (x > SMAX) return SMAX[DW-1:0];
    if (x < SMIN) return SMIN[DW-1:0];
    return x[DW-1:0];
  endfunction

  logic signed [DW-1:0] vmem_q [NUM_CH];
  logic        [RW-1:0] refr_q [NUM_CH];

  adex_state_e          state_q;
  logic [CW-1:0]        ch_q;
  logic                 disc_q;
  logic signed [DW-1:0] cur_q;
  logic signed [DW-1:0] v_q;
  logic signed [DW-1:0] exp_q;
  logic        [RW-1:0] rl_q;
  logic        [RW-1:0] nr_q;
  logic                 spk_q;
  logic [CW-1:0]        sch_q;
  logic signed [DW-1:0] ov_q;

  logic signed [DW-1:0] lut_o;

  logic signed [XW-1:0] v_x;
  logic signed [XW-1:0] leak;
  logic signed [XW-1:0] sum;
  logic signed [DW-1:0] vn;
  logic                 fire;
  logic signed [DW-1:0] nv_d;
  logic        [RW-1:0] nr_d;
  logic                 spk_d;

`ifdef ADEX_ADAPT_EN
  logic signed [DW-1:0] w_q [NUM_CH];
  logic signed [DW-1:0] wl_q;
  logic signed [DW-1:0] ow_q;
  logic signed [XW-1:0] w_x;
  logic signed [DW-1:0] wd;
  logic signed [DW-1:0] wb;
  logic signed [DW-1:0] nw_d;

  assign w_x = XW'(wl_q);
  assign wd  = sat(w_x - (w_x >>> TAUW_SHIFT));
  assign wb  = sat(XW'(wd) + XW'(B));
`else
  logic signed [XW-1:0] w_x;

  assign w_x = '0;
`endif

  adex_exp_lut #(
    .DW       (DW),
    .LUT_DEPTH(LUT_DEPTH)
  ) u_lut (
    .v_i  (v_q),
    .exp_o(lut_o)
  );

  // Refractory channels are pinned to V_RESET and ignore the input.
  always_comb begin
    v_x   = XW'(v_q);
    leak  = (XW'(V_REST) - v_x) >>> TAU_SHIFT;
    sum   = v_x + leak + XW'(exp_q) + XW'(cur_q) - w_x;
    vn    = sat(sum);
    fire  = (XW'(vn) >= XW'(V_PEAK));
    nv_d  = vn;
    nr_d  = '0;
    spk_d = 1'b0;
`ifdef ADEX_ADAPT_EN
    nw_d  = wd;
`endif
    if (rl_q != '0) begin
      nv_d = DW'(V_RESET);
      nr_d = rl_q - RW'(1);
    end else if (fire) begin
      nv_d  = DW'(V_RESET);
      nr_d  = RW'(REFRAC);
      spk_d = 1'b1;
`ifdef ADEX_ADAPT_EN
      nw_d  = wb;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ch_q    <= '0;
      disc_q  <= 1'b0;
      cur_q   <= '0;
      v_q     <= '0;
      exp_q   <= '0;
      rl_q    <= '0;
      nr_q    <= '0;
      spk_q   <= 1'b0;
      sch_q   <= '0;
      ov_q    <= DW'(V_RESET);
      for (int i = 0; i < NUM_CH; i++) begin
        vmem_q[i] <= DW'(V_RESET);
        refr_q[i] <= '0;
      end
`ifdef ADEX_ADAPT_EN
      wl_q <= '0;
      ow_q <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        w_q[i] <= '0;
      end
`endif
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            ch_q    <= in_ch;
            cur_q   <= in_cur;
            // Out-of-range channels still take a full pass but
            // never touch storage or outputs.
            disc_q  <= (int'(in_ch) >= NUM_CH);
            state_q <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (!disc_q) begin
            v_q  <= vmem_q[ch_q];
            rl_q <= refr_q[ch_q];
`ifdef ADEX_ADAPT_EN
            wl_q <= w_q[ch_q];
`endif
          end
          state_q <= S_EXP;
        end
        S_EXP: begin
          exp_q   <= lut_o;
          state_q <= S_UPDATE;
        end
        S_UPDATE: begin
          if (!disc_q) begin
            spk_q <= spk_d;
            ov_q  <= nv_d;
            nr_q  <= nr_d;
            if (spk_d) sch_q <= ch_q;
`ifdef ADEX_ADAPT_EN
            ow_q  <= nw_d;
`endif
          end
          state_q <= S_WRITE;
        end
        S_WRITE: begin
          spk_q <= 1'b0;
          if (!disc_q) begin
            vmem_q[ch_q] <= ov_q;
            refr_q[ch_q] <= nr_q;
`ifdef ADEX_ADAPT_EN
            w_q[ch_q]    <= ow_q;
`endif
          end
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready    = (state_q == S_IDLE) && !rst;
  assign spike_valid = spk_q;
  assign spike_ch    = sch_q;
  assign out_vmem    = ov_q;
`ifdef ADEX_ADAPT_EN
  assign out_w       = ow_q;
`else
  assign out_w       = '0;
`endif

endmodule

// File: tb/tb_adex_neuron_array.sv
// tb_adex_neuron_array: randomized scoreboard bench for the AdEx array,
// 5 channels so that in_ch values 5..7 are out of range.
module tb_adex_neuron_array;

  localparam int NCH = 5;
  localparam int DW  = 16;
  localparam int CW  = $clog2(NCH);
  localparam int REFRAC_TB = 2;
  localparam int LUT_TB [16] = '{
    4,   6,   9,   13,  19,  28,  41,  60,
    88,  128, 188, 275, 402, 589, 862, 1263
  };
`ifdef ADEX_ADAPT_EN
  localparam bit ADAPT = 1'b1;
`else
  localparam bit ADAPT = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic [CW-1:0]        in_ch = '0;
  logic signed [DW-1:0] in_cur = '0;
  logic                 spike_valid;
  logic [CW-1:0]        spike_ch;
  logic signed [DW-1:0] out_vmem;
  logic signed [DW-1:0] out_w;

  adex_neuron_array #(
    .NUM_CH(NCH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_ch      (in_ch),
    .in_cur     (in_cur),
    .spike_valid(spike_valid),
    .spike_ch   (spike_ch),
    .out_vmem   (out_vmem),
    .out_w      (out_w)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit spk;
    int ch;
    int v;
    int w;
  } exp_t;

  exp_t sbq[$];

  int vectors = 0;
  int miscompares = 0;

  int m_v [NCH];
  int m_w [NCH];
  int m_r [NCH];
  int last_v = 0;
  int last_w = 0;
  int last_xfer = 0;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d at t=%0t",
               name, act, exp, $time);
    end
  endtask

  function automatic int sat(input int x);
    if (x > 32767) return 32767;
    if (x < -32768) return -32768;
    return x;
  endfunction

  // Floor division, so negative values round toward -infinity.
  function automatic int fdiv(input int x, input int d);
    if (x >= 0) return x / d;
    return -((-x + d - 1) / d);
  endfunction

  function automatic int expq(input int v);
    int i;
    if (v < 512) return 0;
    i = (v - 512) / 64;
    if (i > 15) i = 15;
    return LUT_TB[i];
  endfunction

  function automatic int decay(input int w);
    if (!ADAPT) return 0;
    return sat(w - fdiv(w, 16));
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_v[i] = 0;
      m_w[i] = 0;
      m_r[i] = 0;
    end
    last_v = 0;
    last_w = 0;
  endtask

  task automatic model_step(input int ch, input int cur);
    exp_t e;
    int vn;
    int wn;
    e.spk = 1'b0;
    e.ch  = ch;
    if (ch < NCH) begin
      if (m_r[ch] > 0) begin
        m_v[ch] = 0;
        m_w[ch] = decay(m_w[ch]);
        m_r[ch] = m_r[ch] - 1;
      end else begin
        vn = sat(m_v[ch] + fdiv(0 - m_v[ch], 8) + expq(m_v[ch])
                 + cur - m_w[ch]);
        wn = decay(m_w[ch]);
        if (vn >= 1000) begin
          e.spk   = 1'b1;
          m_v[ch] = 0;
          m_w[ch] = ADAPT ? sat(wn + 64) : 0;
          m_r[ch] = REFRAC_TB;
        end else begin
          m_v[ch] = vn;
          m_w[ch] = wn;
        end
      end
      last_v = m_v[ch];
      last_w = m_w[ch];
    end
    e.v = last_v;
    e.w = last_w;
    sbq.push_back(e);
  endtask

  task automatic send(input int ch, input int cur, input bit keep,
                      output int gap);
    int n = 0;
    gap = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_ch    = CW'(ch);
    in_cur   = DW'(cur);
    while (!in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      check("handshake_timeout", 0, 1);
    end else begin
      model_step(ch, cur);
      gap = cyc - last_xfer;
      last_xfer = cyc;
    end
    @(posedge clk);
    if (!keep) begin
      #1 in_valid = 1'b0;
    end
  endtask

  task automatic send_abort(input int ch, input int cur);
    int n = 0;
    exp_t e;
    @(negedge clk);
    in_valid = 1'b1;
    in_ch    = CW'(ch);
    in_cur   = DW'(cur);
    while (!in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      check("abort_handshake_timeout", 0, 1);
    end else begin
      e.spk = 1'b0;
      e.ch  = ch;
      e.v   = 0;
      e.w   = 0;
      sbq.push_back(e);
      model_reset();
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_spike_valid", spike_valid, 0);
    check("rst_spike_ch", spike_ch, 0);
    check("rst_out_vmem", out_vmem, 0);
    check("rst_out_w", out_w, 0);
    model_reset();
    rst = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sbq.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (sbq.size() != 0) check("scoreboard_drain", sbq.size(), 0);
    repeat (3) @(negedge clk);
  endtask

  // Monitor: a handshake seen before an edge means WRITE outputs are
  // visible just after the fourth following rising edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (in_valid && in_ready) begin
        repeat (4) @(posedge clk);
        #1;
        if (sbq.size() == 0) begin
          check("scoreboard_empty", 1, 0);
        end else begin
          e = sbq.pop_front();
          check("spike_valid", spike_valid, e.spk);
          if (e.spk) check("spike_ch", spike_ch, e.ch);
          check("out_vmem", out_vmem, e.v);
          check("out_w", out_w, e.w);
        end
        @(posedge clk);
        #1;
        check("spike_pulse_end", spike_valid, 0);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    int ch;
    int cur;
    int mode;
    model_reset();

    do_reset();

    send(1, 400, 1'b0, g);
    send(1, 0, 1'b0, g);

    send(2, 1200, 1'b0, g);
    send(2, 1200, 1'b0, g);
    send(2, 1200, 1'b0, g);
    send(2, 1200, 1'b0, g);

    send(0, -32768, 1'b0, g);
    send(0, -32768, 1'b0, g);
    send(1, 0, 1'b0, g);
    send(3, 0, 1'b0, g);
    send(4, 0, 1'b0, g);
    drain();

    send(3, 100, 1'b1, g);
    send(5, 900, 1'b1, g);
    check("ready_gap", g, 5);
    send(3, 100, 1'b1, g);
    check("ready_gap", g, 5);
    for (int i = 0; i < 6; i++) begin
      send(int'($urandom_range(0, 7)), 600, 1'b1, g);
      check("ready_gap", g, 5);
    end
    @(negedge clk);
    in_valid = 1'b0;
    drain();

    for (int i = 0; i < 160; i++) begin
      ch   = int'($urandom_range(0, 7));
      mode = int'($urandom_range(0, 9));
      if (mode == 0) cur = -32768;
      else if (mode == 1) cur = 32767;
      else cur = int'($urandom_range(0, 1800)) - 500;
      send(ch, cur, 1'($urandom_range(0, 1)), g);
    end
    @(negedge clk);
    in_valid = 1'b0;
    drain();

    do_reset();
    send(2, 300, 1'b0, g);
    drain();
    send_abort(4, 1200);
    drain();
    check("abort_in_ready", in_ready, 1);
    send(4, 1200, 1'b0, g);
    send(2, 0, 1'b0, g);
    send(1, 0, 1'b0, g);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
